// File: rtl/parity_frame_pkg.sv
// Shared types and helpers for the parity frame transmitter.
package parity_frame_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int DATA_W_DEFAULT = 32;
  localparam int FRAME_BITS     = DATA_W_DEFAULT + 3;
  localparam int PAR_MAX_W      = 64;

  // Callers zero-extend narrower words; zero bits do not change parity.
  function automatic logic par_even(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/parity_frame_tx_bit_timer.sv
// Per-bit cycle counter: runs 0..BIT_CYCLES-1 while enabled, ticks on the last count.
module bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic bit_tick
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign bit_tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clear || bit_tick)
      cnt <= '0;
    else if (en)
      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/parity_frame_tx.sv
// Serialises a data word plus supplied parity as start, data LSB first, parity, stop.
// state  | meaning
// IDLE   | line high, ready for a word
// START  | driving start bit (0)
// DATA   | shifting latched word out LSB first
// PARITY | driving latched parity bit as supplied
// STOP   | driving stop bit (1), frame_done on its last edge
module parity_frame_tx
  import parity_frame_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] datain,
  input  logic              parity_bit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done,
  output logic              parity_err
);

  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] shift_q;
  logic              par_q;
  logic [BCW-1:0]    bit_cnt;
  logic              accept;
  logic              timer_en;
  logic              bit_tick;

  assign accept   = in_valid && in_ready;
  assign timer_en = (state != IDLE);

  bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .en       (timer_en),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx_out     <= 1'b1;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      parity_err <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          shift_q    <= datain;
          par_q      <= parity_bit;
          parity_err <= (parity_bit != par_even(PAR_MAX_W'(datain)));
          state      <= START;
          tx_out     <= 1'b0;
          in_ready   <= 1'b0;
          busy       <= 1'b1;
          bit_cnt    <= '0;
        end
        START: if (bit_tick) begin
          state   <= DATA;
          tx_out  <= shift_q[0];
          shift_q <= shift_q >> 1;
        end
        DATA: if (bit_tick) begin
          // bit 0 went out on entry, so the last tick here ends bit DATA_W-1
          if (bit_cnt == LAST_BIT) begin
            state   <= PARITY;
            tx_out  <= par_q;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + BCW'(1);
            tx_out  <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
        PARITY: if (bit_tick) begin
          state  <= STOP;
          tx_out <= 1'b1;
        end
        STOP: if (bit_tick) begin
          state      <= IDLE;
          in_ready   <= 1'b1;
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench for parity_frame_tx: a BIT_CYCLES=4 and a BIT_CYCLES=1 instance
// compared against a per-clock frame model built from the frame layout.
module tb_parity_frame_tx;
  import parity_frame_pkg::*;

  localparam int BC_A  = 4;
  localparam int BC_B  = 1;
  localparam int LEN_A = FRAME_BITS * BC_A;
  localparam int LEN_B = FRAME_BITS * BC_B;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] d_a = '0, d_b = '0;
  logic p_a = 1'b0, p_b = 1'b0, v_a = 1'b0, v_b = 1'b0;
  logic ready_a, tx_a, busy_a, done_a, perr_a;
  logic ready_b, tx_b, busy_b, done_b, perr_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_frame_tx #(.DATA_W(32), .BIT_CYCLES(BC_A)) dut_a (
    .clk(clk), .rst(rst), .datain(d_a), .parity_bit(p_a), .in_valid(v_a),
    .in_ready(ready_a), .tx_out(tx_a), .busy(busy_a), .frame_done(done_a), .parity_err(perr_a));

  parity_frame_tx #(.DATA_W(32), .BIT_CYCLES(BC_B)) dut_b (
    .clk(clk), .rst(rst), .datain(d_b), .parity_bit(p_b), .in_valid(v_b),
    .in_ready(ready_b), .tx_out(tx_b), .busy(busy_b), .frame_done(done_b), .parity_err(perr_b));

  // Expected line level for each clock after accept: bit k/bc of {start, data LSB first, parity, stop}.
  function automatic logic [139:0] model_frame(input logic [31:0] d, input logic p, input int bc);
    logic [139:0] f;
    f = '0;
    for (int k = 0; k < FRAME_BITS * bc; k++) begin
      int b;
      b = k / bc;
      if (b == 0)       f[k] = 1'b0;
      else if (b <= 32) f[k] = d[b-1];
      else if (b == 33) f[k] = p;
      else              f[k] = 1'b1;
    end
    return f;
  endfunction

  function automatic logic even_par(input logic [31:0] d);
    return (($countones(d) & 1) == 1);
  endfunction

  // Presents one word, then records the line and status for the whole frame window.
  task automatic capture(input bit use_b, input logic [31:0] d, input logic p,
                         output logic [139:0] tr, output int lat, output int ndone,
                         output logic perr, output logic acc_ok, output logic busy_ok);
    int len;
    logic tx, dn, bs, rd;
    len = use_b ? LEN_B : LEN_A;
    tr = '0; lat = -1; ndone = 0; busy_ok = 1'b1;
    @(negedge clk);
    acc_ok = use_b ? ready_b : ready_a;
    if (use_b) begin d_b = d; p_b = p; v_b = 1'b1; end
    else       begin d_a = d; p_a = p; v_a = 1'b1; end
    @(posedge clk); #1;
    perr = use_b ? perr_b : perr_a;
    if (use_b) begin v_b = 1'b0; d_b = $urandom(); p_b = ~p; end
    else       begin v_a = 1'b0; d_a = $urandom(); p_a = ~p; end
    for (int k = 0; k < len + 6; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      tx = use_b ? tx_b : tx_a;
      dn = use_b ? done_b : done_a;
      bs = use_b ? busy_b : busy_a;
      rd = use_b ? ready_b : ready_a;
      if (k < len) begin
        tr[k] = tx;
        if (!(bs === 1'b1 && rd === 1'b0)) busy_ok = 1'b0;
      end
      if (dn === 1'b1) begin
        ndone++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({tx_a, ready_a, busy_a, done_a, perr_a} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_a got %b want 11000", {tx_a, ready_a, busy_a, done_a, perr_a});
    end
    checks++;
    if ({tx_b, ready_b, busy_b, done_b, perr_b} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_b got %b want 11000", {tx_b, ready_b, busy_b, done_b, perr_b});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] dd [4] = '{32'd0, 32'd128, 32'd254, 32'hFFFF_FFFF};
    logic        pp [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    bit          ub [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [139:0] tr, exp;
    int lat, ndone, len;
    logic perr, acc_ok, busy_ok, exp_perr;
    for (int i = 0; i < 4; i++) begin
      capture(ub[i], dd[i], pp[i], tr, lat, ndone, perr, acc_ok, busy_ok);
      len = FRAME_BITS * (ub[i] ? BC_B : BC_A);
      exp = model_frame(dd[i], pp[i], ub[i] ? BC_B : BC_A);
      exp_perr = (pp[i] != even_par(dd[i]));
      checks++;
      if (tr !== exp) begin errors++; $display("FAIL dir%0d_trace got %h want %h", i, tr, exp); end
      checks++;
      if (lat != len) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, len); end
      checks++;
      if (ndone != 1) begin errors++; $display("FAIL dir%0d_done_pulses got %0d want 1", i, ndone); end
      checks++;
      if (perr !== exp_perr) begin errors++; $display("FAIL dir%0d_parity_err got %b want %b", i, perr, exp_perr); end
      checks++;
      if ({acc_ok, busy_ok} !== 2'b11) begin errors++; $display("FAIL dir%0d_handshake got %b want 11", i, {acc_ok, busy_ok}); end
    end
  endtask

  task automatic test_random();
    logic [139:0] tr, exp;
    logic [31:0] d;
    logic p, perr, acc_ok, busy_ok, exp_perr;
    int lat, ndone, len;
    bit ub;
    for (int i = 0; i < 8; i++) begin
      d = $urandom();
      p = 1'($urandom_range(0, 1));
      ub = bit'(i & 1);
      capture(ub, d, p, tr, lat, ndone, perr, acc_ok, busy_ok);
      len = FRAME_BITS * (ub ? BC_B : BC_A);
      exp = model_frame(d, p, ub ? BC_B : BC_A);
      exp_perr = (p != even_par(d));
      checks++;
      if (tr !== exp) begin errors++; $display("FAIL rnd%0d_trace d=%h got %h want %h", i, d, tr, exp); end
      checks++;
      if (lat != len) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, len); end
      checks++;
      if (perr !== exp_perr) begin errors++; $display("FAIL rnd%0d_parity_err got %b want %b", i, perr, exp_perr); end
      checks++;
      if ({acc_ok, busy_ok, ndone == 1} !== 3'b111) begin
        errors++; $display("FAIL rnd%0d_handshake got %b want 111", i, {acc_ok, busy_ok, ndone == 1});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [289:0] otx, ordy, odn, etx, erdy, edn;
    logic [139:0] f1, f2;
    bit switched;
    switched = 1'b0;
    f1 = model_frame(32'd439, even_par(32'd439), BC_A);
    f2 = model_frame(32'd369, even_par(32'd369), BC_A);
    etx = '1; erdy = '1; edn = '0;
    for (int i = 0; i < LEN_A; i++) begin
      etx[i] = f1[i]; etx[LEN_A + 1 + i] = f2[i];
      erdy[i] = 1'b0; erdy[LEN_A + 1 + i] = 1'b0;
    end
    edn[LEN_A] = 1'b1; edn[2 * LEN_A + 1] = 1'b1;
    @(negedge clk);
    d_a = 32'd439; p_a = even_par(32'd439); v_a = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 290; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      otx[k] = tx_a; ordy[k] = ready_a; odn[k] = done_a;
      if (done_a === 1'b1 && !switched) begin
        d_a = 32'd369; p_a = even_par(32'd369); switched = 1'b1;
      end
      if (k == 2 * LEN_A + 1) v_a = 1'b0;
    end
    v_a = 1'b0;
    checks++;
    if (otx !== etx) begin errors++; $display("FAIL b2b_trace got %h want %h", otx, etx); end
    checks++;
    if (ordy !== erdy) begin errors++; $display("FAIL b2b_ready got %h want %h", ordy, erdy); end
    checks++;
    if (odn !== edn) begin errors++; $display("FAIL b2b_done got %h want %h", odn, edn); end
  endtask

  task automatic test_reset_mid_frame();
    logic [139:0] tr, exp;
    logic [31:0] d;
    logic perr, acc_ok, busy_ok;
    int lat, ndone;
    @(negedge clk);
    d_a = 32'd711; p_a = even_par(32'd711); v_a = 1'b1;
    @(posedge clk); #1 v_a = 1'b0;
    repeat (50) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({tx_a, ready_a, busy_a, done_a, perr_a} !== 5'b11000) begin
      errors++;
      $display("FAIL midrst_outputs got %b want 11000", {tx_a, ready_a, busy_a, done_a, perr_a});
    end
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    d = $urandom();
    capture(1'b0, d, even_par(d), tr, lat, ndone, perr, acc_ok, busy_ok);
    exp = model_frame(d, even_par(d), BC_A);
    checks++;
    if (tr !== exp) begin errors++; $display("FAIL midrst_fresh_trace got %h want %h", tr, exp); end
    checks++;
    if (lat != LEN_A) begin errors++; $display("FAIL midrst_latency got %0d want %0d", lat, LEN_A); end
    checks++;
    if ({acc_ok, busy_ok, perr} !== 3'b110) begin
      errors++; $display("FAIL midrst_handshake got %b want 110", {acc_ok, busy_ok, perr});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
